// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - arbitrates the external memory bus between the fetch and data ports.
// Round-robin on ties, a watchdog on every bus cycle, and a combinational stall vector.
module bus_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic [5:0]  stall_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [7:0] wait_cnt;
  logic       grant_if;
  logic       grant_mem;

  // On a tie, the port that did not win last time gets the bus.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (if_req_i && mem_req_i) begin
      if (last_grant == OWN_MEM) grant_if = 1'b1;
      else                       grant_mem = 1'b1;
    end else if (if_req_i) begin
      grant_if = 1'b1;
    end else if (mem_req_i) begin
      grant_mem = 1'b1;
    end
  end

  always_comb begin
    stall_o = 6'b000000;
    if (mem_req_i && !mem_ack_o)     stall_o = 6'b011111;
    else if (if_req_i && !if_ack_o)  stall_o = 6'b000011;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      last_grant  <= OWN_MEM;
      wait_cnt    <= 8'd0;
      if_rdata_o  <= 32'd0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= 32'd0;
      mem_ack_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'd0;
      bus_addr_o  <= 32'd0;
      bus_wdata_o <= 32'd0;
      bus_err_o   <= 1'b0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b1111;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= 32'd0;
            owner       <= OWN_IF;
            last_grant  <= OWN_IF;
            wait_cnt    <= 8'd0;
            state       <= XFER;
          end else if (grant_mem) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_sel_o   <= mem_sel_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            owner       <= OWN_MEM;
            last_grant  <= OWN_MEM;
            wait_cnt    <= 8'd0;
            state       <= XFER;
          end
        end
        XFER: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (owner == OWN_IF) begin
              if_rdata_o <= bus_rdata_i;
              if_ack_o   <= 1'b1;
            end else begin
              mem_rdata_o <= bus_we_o ? 32'd0 : bus_rdata_i;
              mem_ack_o   <= 1'b1;
            end
            state <= ACK;
          end else if (wait_cnt == WAIT_LAST) begin
            // Watchdog abort: the requester still gets its ack, with zero data.
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            if (owner == OWN_IF) begin
              if_rdata_o <= 32'd0;
              if_ack_o   <= 1'b1;
            end else begin
              mem_rdata_o <= 32'd0;
              mem_ack_o   <= 1'b1;
            end
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the single external memory bus between the instruction-fetch port (pc_reg/if_id side) and the data-access port (mem stage) of the openmips pipeline. It latches the granted request, runs a variable-latency req/ack transaction with a watchdog, and returns read data with a one-cycle ack pulse. It also drives the pipeline stall vector while either port waits.

## Interface
- MAX_WAIT, 255: bus wait cycles before a transaction is aborted (1..255; counter is 8 bits)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held high until if_ack_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle completion pulse to fetch port
- mem_req_i  in  1  data request; held high until mem_ack_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read data; valid while mem_ack_o=1
- mem_ack_o  out  1  one-cycle completion pulse to data port
- bus_req_o  out  1  bus cycle active
- bus_we_o  out  1  bus write enable (0 for fetches)
- bus_sel_o  out  4  bus byte enables (4'b1111 for fetches)
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data (0 for fetches)
- bus_rdata_i  in  32  bus read data, sampled when bus_ack_i=1
- bus_ack_i  in  1  bus completion
- bus_err_o  out  1  one-cycle pulse on watchdog abort
- stall_o  out  6  pipeline stall: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb

## Operation
- States: IDLE, XFER, ACK. Registers: owner (IF/MEM), last_grant, wait_cnt[7:0].
- IDLE: no requests → stay. Only one req → grant it. Both → grant IF if last_grant==MEM, else MEM. On grant, latch addr, we, sel and wdata into bus_* registers. Fetch grants force we=0, sel=4'b1111, wdata=0. Set bus_req_o=1, owner, last_grant; wait_cnt=0; go to XFER.
- XFER, bus_ack_i=1: capture bus_rdata_i into owner's rdata_o (write: rdata_o=0). bus_req_o←0. Assert owner's ack_o. Go to ACK.
- XFER, no ack, wait_cnt==MAX_WAIT-1: abort. bus_req_o←0, owner's rdata_o←0, owner's ack_o←1, bus_err_o←1. Go to ACK. Otherwise wait_cnt+1.
- ACK: ack_o and bus_err_o deassert next edge. rdata_o holds until the next capture. Next state is IDLE; arbitration resumes there.
- A request dropped mid-transaction does not cancel it. The bus cycle completes and the ack still pulses. Requesters must hold req and payload until ack.
- stall_o is combinational:
  - mem_req_i=1 and mem_ack_o=0 → 6'b011111.
  - Else if_req_i=1 and if_ack_o=0 → 6'b000011.
  - Else 6'b000000.
- Both ports at the same time: the MEM stall pattern dominates.

## Timing
- Reset (rst=1 at edge): state IDLE, last_grant=MEM (first tie goes to IF), wait_cnt=0. All outputs 0 except stall_o, which follows its combinational rule with ack_o=0.
- Request seen in IDLE at edge N: bus_req_o=1 from N+1. Bus ack sampled at edge N+1+w (w ≥ 0 wait cycles). ack_o high in the cycle after that edge. bus_req_o low in that same cycle.
- Minimum request-to-ack is 3 cycles. Back-to-back transactions are spaced ≥ 3 cycles (XFER, ACK, IDLE).
- Watchdog: with no bus_ack_i, bus_req_o is high for exactly MAX_WAIT cycles. ack_o and bus_err_o then pulse together for 1 cycle.
- bus_ack_i while in IDLE or ACK is ignored.
- Reset mid-transaction: bus_req_o low after that edge. A late bus_ack_i is ignored. No ack_o is produced.

## Test plan
- Fetch read, bus ack at 2 wait cycles, bus_rdata_i=32'h3401_1100:
  - if_ack_o pulses 1 cycle, 5 cycles after request; if_rdata_o=32'h3401_1100.
  - bus_we_o=0, bus_sel_o=4'hF.
  - stall_o=6'b000011 until the ack cycle.
- Data write, addr 32'h0000_0040, wdata 32'h1234_5678, sel 4'b0011, ack at 0 waits:
  - bus outputs carry those values; mem_ack_o pulses 3 cycles after request.
  - stall_o=6'b011111 meanwhile.
- Both requests held continuously, immediate bus ack:
  - grants alternate IF, MEM, IF, MEM starting with IF after reset.
  - stall_o=6'b011111 until mem_ack_o.
- MAX_WAIT=4, bus_ack_i never asserted:
  - bus_req_o high exactly 4 cycles; then mem_ack_o=1, bus_err_o=1, mem_rdata_o=0 for 1 cycle; back to IDLE.
- rst asserted during XFER, bus_ack_i asserted the next cycle:
  - all outputs 0, no ack pulse; a following request is served normally.
- mem_req_i dropped one cycle after grant:
  - transaction completes; mem_ack_o still pulses once.
  - no second bus cycle unless the request is re-raised.
